// File: rtl/vending_machine_param_if.sv
// Coin/cancel inputs and vend/change/status outputs of the vending machine.
interface vending_machine_param_if #(
    parameter int CW = 4
);
    logic          pHalf;
    logic          pOne;
    logic          pTwo;
    logic          cancel;
    logic          PCola;
    logic          PChange;
    logic          coin_rej;
    logic [CW-1:0] credit;
    logic          busy;

    modport master (
        output pHalf, pOne, pTwo, cancel,
        input  PCola, PChange, coin_rej, credit, busy
    );

    modport slave (
        input  pHalf, pOne, pTwo, cancel,
        output PCola, PChange, coin_rej, credit, busy
    );
endinterface

// File: rtl/vending_machine_param.sv
// Parameterised vending machine: accumulates half-unit credit, vends at PRICE,
// then returns the remainder as one PChange pulse per half-unit.
//
// state  | meaning
// ACCUM  | idle / collecting coins, cancel starts a full refund
// VEND   | one cycle, dispenses the item and deducts PRICE
// CHANGE | returns one half-unit per cycle until credit reaches 0
module vending_machine_param #(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 15,
    parameter int CW         = 4
) (
    input logic                   sys_clk,
    input logic                   sys_rst_n,
    vending_machine_param_if.slave bus
);
    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [CW:0]   MAX_C   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW:0]   PRICE_C = (CW+1)'(PRICE);
    localparam logic [CW-1:0] PRICE_R = CW'(PRICE);
    localparam logic [CW-1:0] CR_ONE  = CW'(1);

    state_t        state;
    logic [CW-1:0] credit_q;
    logic          pcola_q;
    logic          pchange_q;
    logic          coin_rej_q;
    logic          busy_q;

    logic [1:0]    coin_cnt;
    logic [2:0]    coin_val;
    logic          any_coin;
    logic [CW:0]   sum;

    // Decode the coin inputs; sum is one bit wider so overflow past MAX_CREDIT is visible.
    always_comb begin
        coin_cnt = {1'b0, bus.pHalf} + {1'b0, bus.pOne} + {1'b0, bus.pTwo};
        any_coin = (coin_cnt != 2'd0);
        coin_val = 3'd0;
        if (bus.pTwo)
            coin_val = 3'd4;
        else if (bus.pOne)
            coin_val = 3'd2;
        else if (bus.pHalf)
            coin_val = 3'd1;
        sum = {1'b0, credit_q} + {{(CW-2){1'b0}}, coin_val};
    end

    // Controller FSM with registered pulse outputs; busy tracks VEND/CHANGE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ACCUM;
            credit_q   <= '0;
            pcola_q    <= 1'b0;
            pchange_q  <= 1'b0;
            coin_rej_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pcola_q    <= 1'b0;
            pchange_q  <= 1'b0;
            coin_rej_q <= 1'b0;
            case (state)
                ACCUM: begin
                    if (bus.cancel) begin
                        // cancel beats any coin offered in the same cycle
                        coin_rej_q <= any_coin;
                        if (credit_q != '0) begin
                            state  <= CHANGE;
                            busy_q <= 1'b1;
                        end
                    end else if (coin_cnt > 2'd1) begin
                        coin_rej_q <= 1'b1;
                    end else if (coin_cnt == 2'd1) begin
                        if (sum <= MAX_C) begin
                            credit_q <= sum[CW-1:0];
                            if (sum >= PRICE_C) begin
                                state  <= VEND;
                                busy_q <= 1'b1;
                            end
                        end else begin
                            coin_rej_q <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    coin_rej_q <= any_coin;
                    pcola_q    <= 1'b1;
                    credit_q   <= credit_q - PRICE_R;
                    if (credit_q != PRICE_R) begin
                        state <= CHANGE;
                    end else begin
                        state  <= ACCUM;
                        busy_q <= 1'b0;
                    end
                end
                CHANGE: begin
                    coin_rej_q <= any_coin;
                    if (credit_q != '0) begin
                        pchange_q <= 1'b1;
                        credit_q  <= credit_q - CR_ONE;
                        if (credit_q == CR_ONE) begin
                            state  <= ACCUM;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        state  <= ACCUM;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ACCUM;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PCola    = pcola_q;
    assign bus.PChange  = pchange_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.credit   = credit_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: default instance plus an
// over-ridden PRICE=6 / MAX_CREDIT=5 instance for the overflow case.
module tb_vending_machine_param;
    logic sys_clk;
    logic sys_rst_n;
    int   total;
    int   bad;

    vending_machine_param_if #(.CW(4)) vif  ();
    vending_machine_param_if #(.CW(4)) vif2 ();

    vending_machine_param #(.PRICE(4), .MAX_CREDIT(15), .CW(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (vif.slave)
    );

    vending_machine_param #(.PRICE(6), .MAX_CREDIT(5), .CW(4)) dut2 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (vif2.slave)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // compare one observed value against its hand-computed expectation
    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // check all outputs of the default instance at once
    task automatic chk_all(input string tag, input int cr, input int cola,
                           input int chg, input int rej, input int bsy);
        chk({tag, ".credit"},   int'(vif.credit),   cr);
        chk({tag, ".PCola"},    int'(vif.PCola),    cola);
        chk({tag, ".PChange"},  int'(vif.PChange),  chg);
        chk({tag, ".coin_rej"}, int'(vif.coin_rej), rej);
        chk({tag, ".busy"},     int'(vif.busy),     bsy);
    endtask

    // present inputs for one rising edge (called at a falling edge), then clear them
    task automatic tick(input logic h, input logic o, input logic t, input logic c);
        vif.pHalf = h; vif.pOne = o; vif.pTwo = t; vif.cancel = c;
        @(negedge sys_clk);
        vif.pHalf = 1'b0; vif.pOne = 1'b0; vif.pTwo = 1'b0; vif.cancel = 1'b0;
    endtask

    task automatic tick2(input logic h, input logic o, input logic t, input logic c);
        vif2.pHalf = h; vif2.pOne = o; vif2.pTwo = t; vif2.cancel = c;
        @(negedge sys_clk);
        vif2.pHalf = 1'b0; vif2.pOne = 1'b0; vif2.pTwo = 1'b0; vif2.cancel = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vif.pHalf = 1'b0; vif.pOne = 1'b0; vif.pTwo = 1'b0; vif.cancel = 1'b0;
        vif2.pHalf = 1'b0; vif2.pOne = 1'b0; vif2.pTwo = 1'b0; vif2.cancel = 1'b0;
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk_all("rst", 0, 0, 0, 0, 0);
        sys_rst_n = 1'b1;

        // overflow on the PRICE=6, MAX_CREDIT=5 instance
        tick2(0, 0, 1, 0);
        chk("ovf1.credit", int'(vif2.credit), 4);
        chk("ovf1.rej",    int'(vif2.coin_rej), 0);
        tick2(0, 0, 1, 0);
        chk("ovf2.credit", int'(vif2.credit), 4);
        chk("ovf2.rej",    int'(vif2.coin_rej), 1);
        tick2(0, 0, 0, 0);
        chk("ovf3.rej",    int'(vif2.coin_rej), 0);
        chk("ovf3.busy",   int'(vif2.busy), 0);

        // exact price: pOne, pOne
        tick(0, 1, 0, 0); chk_all("ex1", 2, 0, 0, 0, 0);
        tick(0, 1, 0, 0); chk_all("ex2", 4, 0, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("ex3", 0, 1, 0, 0, 0);
        tick(0, 0, 0, 0); chk_all("ex4", 0, 0, 0, 0, 0);

        // remainder 3: pHalf, pOne, pTwo
        tick(1, 0, 0, 0); chk_all("ch1", 1, 0, 0, 0, 0);
        tick(0, 1, 0, 0); chk_all("ch2", 3, 0, 0, 0, 0);
        tick(0, 0, 1, 0); chk_all("ch3", 7, 0, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("ch4", 3, 1, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("ch5", 2, 0, 1, 0, 1);
        tick(0, 0, 0, 0); chk_all("ch6", 1, 0, 1, 0, 1);
        tick(0, 0, 0, 0); chk_all("ch7", 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0); chk_all("ch8", 0, 0, 0, 0, 0);

        // double coin rejected, then cancel refunds 2
        tick(0, 1, 0, 0); chk_all("dc1", 2, 0, 0, 0, 0);
        tick(1, 1, 0, 0); chk_all("dc2", 2, 0, 0, 1, 0);
        tick(0, 0, 0, 1); chk_all("dc3", 2, 0, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("dc4", 1, 0, 1, 0, 1);
        tick(0, 0, 0, 0); chk_all("dc5", 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0); chk_all("dc6", 0, 0, 0, 0, 0);

        // cancel with zero credit does nothing
        tick(0, 0, 0, 1); chk_all("cz1", 0, 0, 0, 0, 0);

        // coin while in CHANGE is rejected without disturbing the refund
        tick(1, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 1, 0);
        chk_all("bz1", 7, 0, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("bz2", 3, 1, 0, 0, 1);
        tick(0, 0, 1, 0); chk_all("bz3", 2, 0, 1, 1, 1);
        tick(0, 0, 0, 0); chk_all("bz4", 1, 0, 1, 0, 1);
        tick(0, 0, 0, 0); chk_all("bz5", 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0); chk_all("bz6", 0, 0, 0, 0, 0);

        // cancel and pOne together with credit 1
        tick(1, 0, 0, 0); chk_all("cc1", 1, 0, 0, 0, 0);
        tick(0, 1, 0, 1); chk_all("cc2", 1, 0, 0, 1, 1);
        tick(0, 0, 0, 0); chk_all("cc3", 0, 0, 1, 0, 0);
        tick(0, 0, 0, 0); chk_all("cc4", 0, 0, 0, 0, 0);

        // reset in the middle of a 3-pulse refund
        tick(1, 0, 0, 0); tick(0, 1, 0, 0); tick(0, 0, 1, 0);
        tick(0, 0, 0, 0); chk_all("rc1", 3, 1, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("rc2", 2, 0, 1, 0, 1);
        tick(0, 0, 0, 0); chk_all("rc3", 1, 0, 1, 0, 1);
        sys_rst_n = 1'b0;
        #1;
        chk_all("rc_rst", 0, 0, 0, 0, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick(0, 0, 0, 0); chk_all("rc4", 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0); chk_all("rc5", 0, 0, 0, 0, 0);

        // first edge after reset release accepts a coin
        tick(0, 0, 1, 0); chk_all("fr1", 4, 0, 0, 0, 1);
        tick(0, 0, 0, 0); chk_all("fr2", 0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
